// File: rtl/monster_spawn_controller_if.sv
// -----------------------------------------------------------------------------
// monster_spawn_controller_if
// Groups the game-side signals of the top-monster spawn controller.
//   tick             : game-time enable, one Clk wide (game -> controller)
//   top_monster_vga  : renderer alive flag; low while alive = laser kill
//   top_monster_ctrl : request to display the top monster (controller -> game)
//   top_broken       : top shield broken indication
//   score[7:0]       : monsters killed, saturating
//   lives[1:0]       : remaining lives
//   game_over        : high once lives reach 0
// Modports: master = game/renderer side, slave = controller side.
// -----------------------------------------------------------------------------
interface monster_spawn_controller_if;
    logic       tick;
    logic       top_monster_vga;
    logic       top_monster_ctrl;
    logic       top_broken;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output tick,
        output top_monster_vga,
        input  top_monster_ctrl,
        input  top_broken,
        input  score,
        input  lives,
        input  game_over
    );

    modport slave (
        input  tick,
        input  top_monster_vga,
        output top_monster_ctrl,
        output top_broken,
        output score,
        output lives,
        output game_over
    );
endinterface

// File: rtl/monster_spawn_controller.sv
// -----------------------------------------------------------------------------
// monster_spawn_controller
// Sequences one top monster: wait in IDLE, show it while ALIVE, count a laser
// kill or break the shield on timeout, and stop in OVER when lives run out.
// Ports:
//   Clk    : system clock (same slow clock as the renderer)
//   Reset  : synchronous, active-low reset
//   bus    : monster_spawn_controller_if.slave (tick, top_monster_vga in;
//            top_monster_ctrl, top_broken, score, lives, game_over out)
// Optional feature macro: MONSTER_RANDOM_SPAWN_EN -- adds an 8-bit LFSR that
// randomises the spawn delay by 0..31 ticks. Undefined: fixed SPAWN_DELAY.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting spawn_target ticks before the monster appears
// ALIVE   | monster shown; waits for a kill or ATTACK_TIME ticks
// KILLED  | one-cycle kill acknowledge, score incremented
// BROKEN  | shield broken for BROKEN_HOLD ticks, one life lost
// OVER    | no lives left; holds until reset
// -----------------------------------------------------------------------------
module monster_spawn_controller #(
    parameter int SPAWN_DELAY = 64,
    parameter int ATTACK_TIME = 200,
    parameter int BROKEN_HOLD = 32
) (
    input  logic                          Clk,
    input  logic                          Reset,
    monster_spawn_controller_if.slave     bus
);

    localparam int TMAX_A = (SPAWN_DELAY + 31 > ATTACK_TIME) ? SPAWN_DELAY + 31 : ATTACK_TIME;
    localparam int TMAX   = (TMAX_A > BROKEN_HOLD) ? TMAX_A : BROKEN_HOLD;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] ATTACK_TC = TW'(ATTACK_TIME - 1);
    localparam logic [TW-1:0] BROKEN_TC = TW'(BROKEN_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIVE  = 3'd1,
        S_KILLED = 3'd2,
        S_BROKEN = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    alive_cnt_q, alive_cnt_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic          ctrl_q, broken_q, over_q;
    logic [TW-1:0] spawn_tc;

`ifdef MONSTER_RANDOM_SPAWN_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    logic [7:0]    lfsr_q;
    logic [TW-1:0] spawn_target_q;

    // Target is captured on entry to IDLE so the delay stays fixed while waiting.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            lfsr_q         <= LFSR_SEED;
            spawn_target_q <= TW'(SPAWN_DELAY) + TW'(LFSR_SEED[4:0]);
        end else begin
            if (bus.tick) begin
                lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
            if (state_d == S_IDLE && state_q != S_IDLE) begin
                spawn_target_q <= TW'(SPAWN_DELAY) + TW'(lfsr_q[4:0]);
            end
        end
    end

    assign spawn_tc = spawn_target_q - TW'(1);
`else
    assign spawn_tc = TW'(SPAWN_DELAY - 1);
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        alive_cnt_d = alive_cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;

        case (state_q)
            S_IDLE: begin
                if (bus.tick) begin
                    if (timer_q == spawn_tc) begin
                        state_d     = S_ALIVE;
                        timer_d     = '0;
                        alive_cnt_d = 2'd0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_ALIVE: begin
                if (alive_cnt_q != 2'd3) begin
                    alive_cnt_d = alive_cnt_q + 2'd1;
                end
                // Kill is checked every Clk and takes priority over a timeout tick.
                if (alive_cnt_q >= 2'd2 && !bus.top_monster_vga) begin
                    state_d = S_KILLED;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end else if (bus.tick) begin
                    if (timer_q == ATTACK_TC) begin
                        state_d = S_BROKEN;
                        timer_d = '0;
                        if (lives_q != 2'd0) begin
                            lives_d = lives_q - 2'd1;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_KILLED: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
            S_BROKEN: begin
                if (bus.tick) begin
                    if (timer_q == BROKEN_TC) begin
                        state_d = (lives_q == 2'd0) ? S_OVER : S_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output flags are decoded from the next state so they line up with it.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            alive_cnt_q <= 2'd0;
            score_q     <= 8'd0;
            lives_q     <= 2'd3;
            ctrl_q      <= 1'b0;
            broken_q    <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            alive_cnt_q <= alive_cnt_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            ctrl_q      <= (state_d == S_ALIVE);
            broken_q    <= (state_d == S_BROKEN);
            over_q      <= (state_d == S_OVER);
        end
    end

    assign bus.top_monster_ctrl = ctrl_q;
    assign bus.top_broken       = broken_q;
    assign bus.score            = score_q;
    assign bus.lives            = lives_q;
    assign bus.game_over        = over_q;

endmodule

// File: tb/tb_monster_spawn_controller.sv
`timescale 1ns/1ps
module tb_monster_spawn_controller;
    localparam int SPAWN_DELAY = 4;
    localparam int ATTACK_TIME = 10;
    localparam int BROKEN_HOLD = 3;

    // model phases (bench-only labels)
    localparam int P_WAIT  = 0;
    localparam int P_UP    = 1;
    localparam int P_DEAD  = 2;
    localparam int P_BROKE = 3;
    localparam int P_OVER  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    monster_spawn_controller_if bus();

    monster_spawn_controller #(
        .SPAWN_DELAY(SPAWN_DELAY),
        .ATTACK_TIME(ATTACK_TIME),
        .BROKEN_HOLD(BROKEN_HOLD)
    ) dut (
        .Clk  (clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int m_phase = P_WAIT;
    int m_left  = SPAWN_DELAY;  // ticks remaining in current timed phase
    int m_up    = 0;            // cycles the monster has been visible
    int m_score = 0;
    int m_lives = 3;
    bit chk_en  = 1'b0;
    int ccnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules applied to the inputs sampled at this edge.
    task automatic model_step();
        if (!rst_n) begin
            m_phase = P_WAIT; m_left = SPAWN_DELAY; m_up = 0;
            m_score = 0; m_lives = 3;
        end else begin
            case (m_phase)
                P_WAIT: if (bus.tick) begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_UP; m_left = ATTACK_TIME; m_up = 0; end
                end
                P_UP: begin
                    if (m_up >= 2 && !bus.top_monster_vga) begin
                        m_phase = P_DEAD;
                        m_score = (m_score < 255) ? m_score + 1 : 255;
                    end else if (bus.tick) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = P_BROKE; m_left = BROKEN_HOLD;
                            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        end
                    end
                    m_up++;
                end
                P_DEAD: begin m_phase = P_WAIT; m_left = SPAWN_DELAY; end
                P_BROKE: if (bus.tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = (m_lives == 0) ? P_OVER : P_WAIT;
                        m_left = SPAWN_DELAY;
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ctrl",   int'(bus.top_monster_ctrl), int'(m_phase == P_UP));
            check("broken", int'(bus.top_broken),       int'(m_phase == P_BROKE));
            check("over",   int'(bus.game_over),        int'(m_phase == P_OVER));
            check("score",  int'(bus.score),            m_score);
            check("lives",  int'(bus.lives),            m_lives);
        end
    end

    task automatic cyc(input bit t, input bit v);
        bus.tick = t;
        bus.top_monster_vga = v;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Tick on every 4th clock.
    task automatic clk1(input bit v, output bit t);
        t = (ccnt % 4 == 3);
        ccnt++;
        cyc(t, v);
    endtask

    task automatic wait_spawn(output int nt);
        bit t;
        nt = 0;
        for (int i = 0; i < 300 && !bus.top_monster_ctrl; i++) begin clk1(1'b1, t); nt += t; end
        check("spawn_seen", int'(bus.top_monster_ctrl), 1);
    endtask

    task automatic wait_broken(output int nt);
        bit t;
        nt = 0;
        for (int i = 0; i < 300 && !bus.top_broken; i++) begin clk1(1'b1, t); nt += t; end
        check("broken_seen", int'(bus.top_broken), 1);
    endtask

    task automatic wait_unbroken(output int nt);
        bit t;
        nt = 0;
        for (int i = 0; i < 300 && bus.top_broken; i++) begin clk1(1'b1, t); nt += t; end
        check("broken_end", int'(bus.top_broken), 0);
    endtask

    task automatic do_reset();
        bit t;
        rst_n = 1'b0;
        clk1(1'b1, t);
        rst_n = 1'b1;
    endtask

    initial begin
        bit t;
        int nt, at, seen;
        bit tn;
        int lowp;

        bus.tick = 1'b0;
        bus.top_monster_vga = 1'b1;
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_ctrl",  int'(bus.top_monster_ctrl), 0);
        check("rst_score", int'(bus.score), 0);
        check("rst_lives", int'(bus.lives), 3);
        check("rst_over",  int'(bus.game_over), 0);
        rst_n = 1'b1;

        // first spawn after 4 ticks
        wait_spawn(nt);
        check("spawn_ticks", nt, 4);
        check("spawn_score", int'(bus.score), 0);
        check("spawn_lives", int'(bus.lives), 3);

        // low on first alive cycle is too early; then kill two cycles in
        clk1(1'b0, t);
        check("early_low_ignored", int'(bus.top_monster_ctrl), 1);
        clk1(1'b1, t);
        clk1(1'b0, t);
        check("kill_ctrl",  int'(bus.top_monster_ctrl), 0);
        check("kill_score", int'(bus.score), 1);
        clk1(1'b1, t);
        check("after_kill_ctrl", int'(bus.top_monster_ctrl), 0);
        wait_spawn(nt);
        check("respawn_ticks", nt, 4);

        // timeout path
        wait_broken(nt);
        check("attack_ticks", nt, 10);
        check("broken_lives", int'(bus.lives), 2);
        check("broken_ctrl",  int'(bus.top_monster_ctrl), 0);
        wait_unbroken(nt);
        check("hold_ticks", nt, 3);
        wait_spawn(nt);
        check("spawn_after_broken", nt, 4);

        // two more timeouts end the game
        wait_broken(nt);
        wait_unbroken(nt);
        wait_spawn(nt);
        wait_broken(nt);
        wait_unbroken(nt);
        check("over_flag",  int'(bus.game_over), 1);
        check("over_lives", int'(bus.lives), 0);
        nt = 0; seen = 0;
        for (int i = 0; i < 400 && nt < 50; i++) begin
            clk1(1'($urandom_range(0, 1)), t);
            nt += t;
            seen |= int'(bus.top_monster_ctrl);
        end
        check("over_no_ctrl", seen, 0);
        check("over_held", int'(bus.game_over), 1);

        // kill on the same cycle as the 10th alive tick
        do_reset();
        wait_spawn(nt);
        at = 0;
        for (int i = 0; i < 200; i++) begin
            tn = (ccnt % 4 == 3);
            if (tn && at == 9) begin clk1(1'b0, t); break; end
            clk1(1'b1, t);
            at += t;
        end
        check("tie_score",  int'(bus.score), 1);
        check("tie_lives",  int'(bus.lives), 3);
        check("tie_broken", int'(bus.top_broken), 0);
        check("tie_ctrl",   int'(bus.top_monster_ctrl), 0);
        clk1(1'b1, t);
        check("tie_broken_after", int'(bus.top_broken), 0);

        // reach score 7, then reset during BROKEN
        repeat (6) begin
            wait_spawn(nt);
            clk1(1'b1, t); clk1(1'b1, t); clk1(1'b0, t);
        end
        wait_spawn(nt);
        wait_broken(nt);
        check("pre_rst_score", int'(bus.score), 7);
        do_reset();
        check("rst_brk_score",  int'(bus.score), 0);
        check("rst_brk_lives",  int'(bus.lives), 3);
        check("rst_brk_broken", int'(bus.top_broken), 0);
        check("rst_brk_ctrl",   int'(bus.top_monster_ctrl), 0);
        wait_spawn(nt);
        check("rst_brk_idle_ticks", nt, 4);

        // score saturation: tick every cycle, renderer always reporting a hit
        do_reset();
        repeat (2200) cyc(1'b1, 1'b0);
        check("score_sat", int'(bus.score), 255);
        check("sat_lives", int'(bus.lives), 3);

        // randomized segments, alternating kill-heavy and timeout-heavy
        for (int seg = 0; seg < 20; seg++) begin
            lowp = (seg % 2 == 1) ? 40 : 4;
            repeat (200) begin
                rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
                cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, lowp - 1) != 0));
            end
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
